// File: rtl/dmem_responder.sv
// Single-port word memory that answers one read or write request at a time after a fixed
// latency. Sub-word writes use per-byte lane enables; reads return only the selected lanes.
//
// Parameters:
//   DEPTH   - number of 32-bit words (power of two, >= 4)
//   LATENCY - edges from the accept edge to the edge that samples the response (1..15)
// Ports:
//   i_clk, i_rst_n       - clock, asynchronous active-low reset
//   i_addr               - byte address; [1:0] ignored; bits above the word index flag an error
//   i_ren, i_wen         - read / write request; both high at once is rejected with o_err
//   i_wdata, i_mask      - lane-aligned write data and byte-lane enables
//   o_rdata              - masked read data, zero whenever o_valid is low
//   o_busy               - a request is in flight; new requests are ignored
//   o_valid, o_err       - one-cycle response strobe and error flag
module dmem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_addr,
    input  logic        i_ren,
    input  logic        i_wen,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_mask,
    output logic [31:0] o_rdata,
    output logic        o_busy,
    output logic        o_valid,
    output logic        o_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] idx_q;
    logic          wr_q;
    logic          oor_q;
    logic [3:0]    mask_q;
    logic [31:0]   wdata_q;
    logic          valid_q;
    logic          err_q;
    logic [31:0]   rdata_q;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] in_idx;
    logic          in_oor;
    logic          accept;
    logic          illegal;
    logic          enter_resp;
    logic [AW-1:0] op_idx;
    logic          op_wr;
    logic          op_oor;
    logic [3:0]    op_mask;
    logic [31:0]   op_wdata;
    logic [31:0]   lane_bits;
    logic [31:0]   rd_word;
    logic          commit;

    assign in_idx  = i_addr[AW+1:2];
    assign in_oor  = (i_addr >> (AW + 2)) != 32'd0;
    assign accept  = i_rst_n && (state_q == StIdle) && (i_ren ^ i_wen);
    assign illegal = (state_q == StIdle) && i_ren && i_wen;

    // With LATENCY == 1 the accept edge is also the edge entering RESP, so the live inputs
    // drive the access; otherwise the captured request does.
    assign enter_resp = (accept && (LATENCY == 1)) || ((state_q == StWait) && (cnt_q == 4'd0));

    always_comb begin
        if (state_q == StIdle) begin
            op_idx   = in_idx;
            op_wr    = i_wen;
            op_oor   = in_oor;
            op_mask  = i_mask;
            op_wdata = i_wdata;
        end else begin
            op_idx   = idx_q;
            op_wr    = wr_q;
            op_oor   = oor_q;
            op_mask  = mask_q;
            op_wdata = wdata_q;
        end
    end

    assign lane_bits = {{8{op_mask[3]}}, {8{op_mask[2]}}, {8{op_mask[1]}}, {8{op_mask[0]}}};
    assign rd_word   = (op_wr || op_oor) ? 32'd0 : (mem[op_idx] & lane_bits);
    assign commit    = i_rst_n && enter_resp && op_wr && !op_oor;

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (commit) begin
            mem[op_idx] <= (mem[op_idx] & ~lane_bits) | (op_wdata & lane_bits);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            oor_q   <= 1'b0;
            mask_q  <= 4'd0;
            wdata_q <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        idx_q   <= in_idx;
                        wr_q    <= i_wen;
                        oor_q   <= in_oor;
                        mask_q  <= i_mask;
                        wdata_q <= i_wdata;
                        if (LATENCY == 1) begin
                            state_q <= StResp;
                            valid_q <= 1'b1;
                            err_q   <= in_oor;
                            rdata_q <= rd_word;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CNT_INIT;
                        end
                    end else if (illegal) begin
                        err_q <= 1'b1;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StResp;
                        valid_q <= 1'b1;
                        err_q   <= oor_q;
                        rdata_q <= rd_word;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_busy  = (state_q != StIdle);
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_rdata = rdata_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH SHALL be: default 1024; number of 32-bit words stored; power of two, minimum 4.
REQ-002 Parameter LATENCY SHALL be: default 2; cycles from request accept to response; legal range 1..15.
REQ-003 Port i_clk SHALL be: input, 1 bit; the only clock; all state updates on its rising edge.
REQ-004 Port i_rst_n SHALL be: input, 1 bit; asynchronous, active-low reset.
REQ-005 Port i_addr SHALL be: input, 32 bits; byte address; bits [1:0] ignored; word index = i_addr[log2(DEPTH)+1:2].
REQ-006 Port i_ren SHALL be: input, 1 bit; read request.
REQ-007 Port i_wen SHALL be: input, 1 bit; write request.
REQ-008 Port i_wdata SHALL be: input, 32 bits; write data, already lane-aligned by the requester.
REQ-009 Port i_mask SHALL be: input, 4 bits; byte-lane enables; bit n selects bits [8n+7:8n].
REQ-010 Port o_rdata SHALL be: output, 32 bits; read data, valid only while o_valid is high.
REQ-011 Port o_busy SHALL be: output, 1 bit; high while a request is in flight; a new request is not accepted.
REQ-012 Port o_valid SHALL be: output, 1 bit; one-cycle response strobe.
REQ-013 Port o_err SHALL be: output, 1 bit; error flag.

Function
REQ-014 The state machine SHALL have exactly three states: IDLE, WAIT and RESP; o_busy = (state != IDLE).
REQ-015 Accept: in IDLE, at a rising edge with exactly one of i_ren/i_wen high, the block SHALL capture word index, op, i_mask and i_wdata.
REQ-016 Accept transitions: if LATENCY = 1 go IDLE->RESP; otherwise go IDLE->WAIT and load the down-counter with LATENCY-2.
REQ-017 WAIT: the counter SHALL decrement each cycle and transition to RESP on the edge where the counter equals 0.
REQ-018 Timing: o_valid SHALL be high for exactly the one cycle in RESP, beginning LATENCY edges after the accept edge.
REQ-019 RESP SHALL return to IDLE unconditionally; a request presented during RESP is ignored.
REQ-020 Throughput: the maximum accept rate SHALL be one request per LATENCY+1 cycles.
REQ-021 Write commit: the captured mask lanes SHALL be written at the edge entering RESP; unmasked lanes are unchanged.
REQ-022 Write with mask 4'b0000: storage is not modified, and o_valid still pulses with o_err = 0.
REQ-023 Read data: during RESP, o_rdata SHALL present the stored word with unmasked lanes forced to 0; o_rdata = 0 whenever o_valid is low.
REQ-024 Read-after-write: a read accepted after a write's RESP cycle SHALL return the written data.
REQ-025 Out-of-range: if any bit of i_addr[31:log2(DEPTH)+2] is set, the request is accepted normally, writes are dropped, reads return 0, and o_err = 1 alongside o_valid.
REQ-026 Illegal request: i_ren and i_wen both high in IDLE SHALL NOT be accepted; state stays IDLE; o_err pulses for one cycle on the following cycle with o_valid = 0.
REQ-027 While o_busy is high, i_addr, i_ren, i_wen, i_wdata and i_mask SHALL be ignored; captured values are used.
REQ-028 Storage contents SHALL NOT be reset, and are undefined until written.

Reset
REQ-029 While i_rst_n = 0, the block SHALL hold state = IDLE, counter = 0, o_busy = 0, o_valid = 0, o_err = 0, o_rdata = 0, independent of i_clk.
REQ-030 Reset during WAIT or RESP SHALL abort the request; a pending write is not committed; no o_valid is produced after release.
REQ-031 The first accept SHALL be possible at the first rising edge with i_rst_n = 1.

Verification
REQ-032 LATENCY=2, write addr 0x10, wdata 0xDEADBEEF, mask 1111; then read 0x10, mask 1111 -> each o_valid exactly 2 edges after its accept; read o_rdata = 0xDEADBEEF, o_err = 0.
REQ-033 Byte write at 0x13: wdata 0xAA000000, mask 1000, over 0x11223344; read mask 1111 -> 0xAA223344; read mask 1100 -> 0xAA220000.
REQ-034 i_ren = i_wen = 1 in IDLE -> o_busy stays 0; o_err high for one cycle; o_valid never rises; storage unchanged.
REQ-035 DEPTH=1024, read 0x00001000 -> o_valid with o_err = 1, o_rdata = 0; write 0x00001000 then read 0x0 -> 0x0 unchanged.
REQ-036 Hold i_ren high continuously, LATENCY=3 -> accepts spaced exactly 4 cycles apart; i_addr changes while busy do not affect o_rdata.
REQ-037 Write 0x55 to 0x20, deassert i_rst_n one cycle after accept, release -> outputs 0 immediately; no o_valid; later read 0x20 -> prior contents, not 0x55.
